// File: rtl/acog_hub_if_if.sv
// Hub-side bus of acog_hub_if: slot grant, request, byte-lane controls and ack
// between one cog's hub access unit (master) and the hub arbiter (slave).
interface acog_hub_if_if #(
    parameter int unsigned HUB_AW = 16
);
    logic              hub_slot_i;
    logic              hub_req_o;
    logic              hub_we_o;
    logic              hub_ctl_o;
    logic [2:0]        hub_code_o;
    logic [HUB_AW-1:0] hub_addr_o;
    logic [3:0]        hub_be_o;
    logic [31:0]       hub_wdata_o;
    logic [31:0]       hub_rdata_i;
    logic              hub_ack_i;

    modport master (
        input  hub_slot_i, hub_rdata_i, hub_ack_i,
        output hub_req_o, hub_we_o, hub_ctl_o, hub_code_o,
               hub_addr_o, hub_be_o, hub_wdata_o
    );

    modport slave (
        output hub_slot_i, hub_rdata_i, hub_ack_i,
        input  hub_req_o, hub_we_o, hub_ctl_o, hub_code_o,
               hub_addr_o, hub_be_o, hub_wdata_o
    );
endinterface

// File: rtl/acog_hub_if.sv
// Cog hub access unit: waits for the hub slot, performs byte/word/long or control access.
// Optional macro ACOG_HUB_ALIGN_ERR_EN turns misaligned word/long accesses into err_o strobes.
module acog_hub_if #(
    parameter int unsigned HUB_AW  = 16,
    parameter int unsigned ACK_MAX = 15
) (
    input  logic          clk_in,
    input  logic          reset_in,
    input  logic          start_i,
    input  logic [4:0]    hub_op_i,
    input  logic [1:0]    hub_tfr_sz_i,
    input  logic [31:0]   addr_i,
    input  logic [31:0]   wdata_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [31:0]   rdata_o,
    output logic          save_d_o,
    output logic          z_o,
    output logic          err_o,
    acog_hub_if_if.master hub
);
    typedef enum logic [1:0] {IDLE, WAIT_SLOT, ACCESS, DONE} state_t;

    state_t            r_state;
    logic              r_is_mem, r_is_rd;
    logic [1:0]        r_sz;
    logic [HUB_AW-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [2:0]        r_code;
    logic              r_busy, r_done, r_save, r_z, r_err;
    logic [31:0]       r_rdata;
    logic              r_req, r_we, r_ctl;
    logic [2:0]        r_hcode;
    logic [HUB_AW-1:0] r_haddr;
    logic [3:0]        r_be;
    logic [31:0]       r_hwdata;

    logic              w_long, w_word, w_misalign, w_rd_or_ctl, w_unused;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata, w_rd;
    logic [HUB_AW-1:0] w_addr;

    // ACK_MAX is reserved for a future ack timeout
    assign w_unused = ^{addr_i[31:HUB_AW], ACK_MAX[0]};

    assign w_rd_or_ctl = !r_is_mem || r_is_rd;

    always_comb begin
        w_long  = r_sz[1];
        w_word  = (r_sz == 2'b01);
        w_addr  = {r_addr[HUB_AW-1:2], 2'b00};
        w_be    = 4'b1111;
        w_wdata = r_wdata;
        w_rd    = hub.hub_rdata_i;
        if (!r_is_mem) begin
            w_addr = '0;
        end else if (w_word) begin
            w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{r_wdata[15:0]}};
            w_rd    = {16'h0, r_addr[1] ? hub.hub_rdata_i[31:16] : hub.hub_rdata_i[15:0]};
        end else if (!w_long) begin
            w_be    = 4'b0001 << r_addr[1:0];
            w_wdata = {4{r_wdata[7:0]}};
            w_rd    = {24'h0, hub.hub_rdata_i[{r_addr[1:0], 3'b000} +: 8]};
        end
    end

`ifdef ACOG_HUB_ALIGN_ERR_EN
    assign w_misalign = r_is_mem && ((w_long && (r_addr[1:0] != 2'b00)) || (w_word && r_addr[0]));
`else
    assign w_misalign = 1'b0;
`endif

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_state  <= IDLE;
            r_is_mem <= 1'b0;
            r_is_rd  <= 1'b0;
            r_sz     <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_code   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_save   <= 1'b0;
            r_z      <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
            r_req    <= 1'b0;
            r_we     <= 1'b0;
            r_ctl    <= 1'b0;
            r_hcode  <= '0;
            r_haddr  <= '0;
            r_be     <= '0;
            r_hwdata <= '0;
        end else begin
            r_done <= 1'b0;
            r_save <= 1'b0;
            r_z    <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_is_mem <= hub_op_i[4];
                        r_is_rd  <= hub_op_i[3];
                        r_code   <= hub_op_i[2:0];
                        r_sz     <= hub_tfr_sz_i;
                        r_addr   <= addr_i[HUB_AW-1:0];
                        r_wdata  <= wdata_i;
                        r_busy   <= 1'b1;
                        r_state  <= WAIT_SLOT;
                    end
                end
                WAIT_SLOT: begin
                    // Misaligned access skips the hub entirely; rdata_o is left as it was
                    if (w_misalign) begin
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                        r_z     <= (r_rdata == '0);
                        r_state <= DONE;
                    end else if (hub.hub_slot_i) begin
                        r_req    <= 1'b1;
                        r_we     <= r_is_mem && !r_is_rd;
                        r_ctl    <= !r_is_mem;
                        r_hcode  <= r_is_mem ? 3'b000 : r_code;
                        r_haddr  <= w_addr;
                        r_be     <= w_be;
                        r_hwdata <= w_wdata;
                        r_state  <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (hub.hub_ack_i) begin
                        r_req    <= 1'b0;
                        r_we     <= 1'b0;
                        r_ctl    <= 1'b0;
                        r_hcode  <= '0;
                        r_haddr  <= '0;
                        r_be     <= '0;
                        r_hwdata <= '0;
                        r_done   <= 1'b1;
                        if (w_rd_or_ctl) begin
                            r_rdata <= w_rd;
                            r_save  <= 1'b1;
                            r_z     <= (w_rd == '0);
                        end else begin
                            r_z     <= (r_rdata == '0);
                        end
                        r_state  <= DONE;
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy_o          = r_busy;
    assign done_o          = r_done;
    assign rdata_o         = r_rdata;
    assign save_d_o        = r_save;
    assign z_o             = r_z;
    assign err_o           = r_err;
    assign hub.hub_req_o   = r_req;
    assign hub.hub_we_o    = r_we;
    assign hub.hub_ctl_o   = r_ctl;
    assign hub.hub_code_o  = r_hcode;
    assign hub.hub_addr_o  = r_haddr;
    assign hub.hub_be_o    = r_be;
    assign hub.hub_wdata_o = r_hwdata;
endmodule
